// File: rtl/shift_sequencer.sv
// shift_sequencer: bit-serial shifter, one bit position per clock.
// Start/busy/done handshake with registered result and C/N/V flags.
module shift_sequencer #(
   parameter int bits = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            dir,
   input  logic            fill,
   input  logic [bits-1:0] inA,
   input  logic [bits-1:0] inB,
   output logic            busy,
   output logic            done,
   output logic [bits-1:0] out,
   output logic            C,
   output logic            N,
   output logic            V
);

   localparam int CW = $clog2(bits + 2);
   localparam logic [CW-1:0] KMAX = CW'(bits + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   k_d;
   logic [bits-1:0] work_q;
   logic [bits-1:0] work_d;
   logic            carry_q;
   logic            carry_d;
   logic            dir_q;
   logic            fill_q;
   logic            busy_q;
   logic            done_q;
   logic [bits-1:0] out_q;
   logic            c_q;
   logic            n_q;

   // Capped step count: any amount above bits+1 gives the same result.
   always_comb begin
      k_d = CW'(inB);
      if (32'(inB) > 32'(bits + 1)) begin
         k_d = KMAX;
      end
   end

   // One shift step of the working register and carry.
   always_comb begin
      work_d  = work_q;
      carry_d = carry_q;
      if (dir_q) begin
         carry_d = work_q[0];
         work_d  = {fill_q, work_q[bits-1:1]};
      end else begin
         carry_d = work_q[bits-1];
         work_d  = {work_q[bits-2:0], fill_q};
      end
   end

   // Sequencer FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         carry_q <= 1'b0;
         dir_q   <= 1'b0;
         fill_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
         c_q     <= 1'b0;
         n_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  work_q  <= inA;
                  dir_q   <= dir;
                  fill_q  <= fill;
                  carry_q <= 1'b0;
                  cnt_q   <= k_d;
                  busy_q  <= 1'b1;
                  if (k_d == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     out_q   <= inA;
                     c_q     <= 1'b0;
                     n_q     <= inA[bits-1];
                  end else begin
                     state_q <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work_q  <= work_d;
               carry_q <= carry_d;
               cnt_q   <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  out_q   <= work_d;
                  c_q     <= carry_d;
                  n_q     <= work_d[bits-1];
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign out  = out_q;
   assign C    = c_q;
   assign N    = n_q;
   assign V    = 1'b0;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven vectors with a scoreboard queue,
// plus back-to-back and reset-abort sequences.
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       dir = 1'b0;
   logic       fill = 1'b0;
   logic [3:0] inA = '0;
   logic [3:0] inB = '0;
   logic       busy;
   logic       done;
   logic [3:0] out;
   logic       C;
   logic       N;
   logic       V;

   always #5 clk = ~clk;

   shift_sequencer #(.bits(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .dir  (dir),
      .fill (fill),
      .inA  (inA),
      .inB  (inB),
      .busy (busy),
      .done (done),
      .out  (out),
      .C    (C),
      .N    (N),
      .V    (V)
   );

   typedef struct {
      string      name;
      logic [3:0] out;
      logic       c;
      logic       n;
      int         cyc;
   } exp_t;

   typedef struct {
      string      name;
      logic       d;
      logic       f;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] o;
      logic       c;
      logic       n;
      int         lat;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t tbl[14];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Compare each done pulse against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'(done), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk({mon_e.name, ".out"}, 32'(out), 32'(mon_e.out));
            chk({mon_e.name, ".C"}, 32'(C), 32'(mon_e.c));
            chk({mon_e.name, ".N"}, 32'(N), 32'(mon_e.n));
            chk({mon_e.name, ".V"}, 32'(V), 32'd0);
            chk({mon_e.name, ".busy"}, 32'(busy), 32'd1);
            chk({mon_e.name, ".cycle"}, 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   task automatic push(input string nm, input logic [3:0] o,
                       input logic c, input logic n, input int at);
      exp_t e;
      e.name = nm;
      e.out  = o;
      e.c    = c;
      e.n    = n;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 12 && sb.size() > 0; i++) @(posedge clk);
      chk({nm, ".timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
      @(negedge clk);
      chk({nm, ".idle_busy"}, 32'(busy), 32'd0);
      chk({nm, ".idle_done"}, 32'(done), 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      dir   = v.d;
      fill  = v.f;
      inA   = v.a;
      inB   = v.b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      push(v.name, v.o, v.c, v.n, cyc + v.lat - 1);
      chk({v.name, ".busy1"}, 32'(busy), 32'd1);
      drain(v.name);
   endtask

   initial begin
      int a0;
      int nd;
      tbl[0]  = '{"left2",      0, 0, 4'b1011, 4'd2,  4'b1100, 0, 1, 3};
      tbl[1]  = '{"right3fill", 1, 1, 4'b0100, 4'd3,  4'b1110, 1, 1, 4};
      tbl[2]  = '{"zero",       0, 1, 4'b0110, 4'd0,  4'b0110, 0, 0, 1};
      tbl[3]  = '{"sat",        0, 1, 4'b0000, 4'd15, 4'b1111, 1, 1, 6};
      tbl[4]  = '{"right1",     1, 0, 4'b1001, 4'd1,  4'b0100, 1, 0, 2};
      tbl[5]  = '{"left4",      0, 0, 4'b1001, 4'd4,  4'b0000, 1, 0, 5};
      tbl[6]  = '{"right4",     1, 0, 4'b1000, 4'd4,  4'b0000, 1, 0, 5};
      tbl[7]  = '{"right5",     1, 0, 4'b1010, 4'd5,  4'b0000, 0, 0, 6};
      tbl[8]  = '{"right15",    1, 1, 4'b0101, 4'd15, 4'b1111, 1, 1, 6};
      tbl[9]  = '{"left1fill",  0, 1, 4'b0011, 4'd1,  4'b0111, 0, 0, 2};
      tbl[10] = '{"left1msb",   0, 0, 4'b1000, 4'd1,  4'b0000, 1, 0, 2};
      tbl[11] = '{"right2",     1, 0, 4'b0111, 4'd2,  4'b0001, 1, 0, 3};
      tbl[12] = '{"left5",      0, 0, 4'b1111, 4'd5,  4'b0000, 0, 0, 6};
      tbl[13] = '{"left3",      0, 0, 4'b0101, 4'd3,  4'b1000, 0, 1, 4};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.done", 32'(done), 32'd0);
      chk("reset.out", 32'(out), 32'd0);
      chk("reset.C", 32'(C), 32'd0);
      chk("reset.N", 32'(N), 32'd0);
      chk("reset.V", 32'(V), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) run_vec(tbl[i]);

      // Reset mid-shift: no done for the aborted command.
      @(negedge clk);
      dir   = 1'b0;
      fill  = 1'b0;
      inA   = 4'b1111;
      inB   = 4'd4;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      push("abort", 4'b0000, 1'b0, 1'b0, cyc + 4);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.out", 32'(out), 32'd0);
      chk("rst.C", 32'(C), 32'd0);
      chk("rst.N", 32'(N), 32'd0);
      nd = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("rst.no_done", 32'(nd), 32'd0);
      run_vec(tbl[0]);

      // Back-to-back with start held high.
      @(negedge clk);
      dir   = 1'b0;
      fill  = 1'b0;
      inA   = 4'b0011;
      inB   = 4'd1;
      start = 1'b1;
      @(posedge clk);
      #1;
      a0 = cyc;
      push("b2b1", 4'b0110, 1'b0, 1'b0, a0 + 1);
      @(negedge clk);
      dir  = 1'b1;
      fill = 1'b0;
      inA  = 4'b1110;
      inB  = 4'd2;
      push("b2b2", 4'b0011, 1'b1, 1'b0, a0 + 5);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("b2b.gap_busy", 32'(busy), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("b2b.second_busy", 32'(busy), 32'd1);
      start = 1'b0;
      drain("b2b");

      chk("final.queue", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
